// File: rtl/multich_moving_avg.sv
// -----------------------------------------------------------------------------
// multich_moving_avg
// Multi-channel boxcar moving-average filter for the audio path. One packed
// frame (all channels) is accepted per handshake; channels are then processed
// one per cycle through a shared datapath with a per-channel circular history.
// Window N = 2^win_sel (clamped to 2^LOG2_MAX). Exact accumulator, floor divide.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous reset, active low
//   i_clear      synchronous flush of fill/accumulators (honoured in IDLE only)
//   i_bypass     1: output the raw input frame with the same latency
//   i_win_sel    log2 of the window length
//   i_in_valid   frame offered
//   o_in_ready   high only while idle and not clearing
//   i_data_in    packed frame, channel c at [c*W +: W]
//   o_out_valid  one-cycle pulse when o_data_out is updated
//   o_data_out   packed result frame, held between pulses
// -----------------------------------------------------------------------------
module multich_moving_avg #(
    parameter int unsigned W        = 24,
    parameter int unsigned CH       = 2,
    parameter int unsigned LOG2_MAX = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_clear,
    input  logic                             i_bypass,
    input  logic [$clog2(LOG2_MAX+1)-1:0]    i_win_sel,
    input  logic                             i_in_valid,
    output logic                             o_in_ready,
    input  logic [CH*W-1:0]                  i_data_in,
    output logic                             o_out_valid,
    output logic [CH*W-1:0]                  o_data_out
);

    localparam int unsigned DMAX = 1 << LOG2_MAX;
    localparam int unsigned AW   = W + LOG2_MAX;
    localparam int unsigned WSW  = $clog2(LOG2_MAX + 1);
    localparam int unsigned CHW  = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned FW   = LOG2_MAX + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t                r_state, w_state_nxt;
    logic [CHW-1:0]        r_ch;
    logic [CH*W-1:0]       r_frame;
    logic [WSW-1:0]        r_win_cur;
    logic [WSW-1:0]        w_win_lat;
    logic [LOG2_MAX-1:0]   r_wp;
    logic [LOG2_MAX-1:0]   w_rd_idx;
    logic [FW-1:0]         r_fill;
    logic [FW-1:0]         w_n;
    logic signed [AW-1:0]  r_acc  [CH];
    logic signed [AW-1:0]  r_hist [CH][DMAX];
    logic [W-1:0]          r_y    [CH];
    logic [W-1:0]          w_xs;
    logic signed [AW-1:0]  w_x;
    logic signed [AW-1:0]  w_old;
    logic signed [AW-1:0]  w_acc_nxt;
    logic [W-1:0]          w_y;
    logic                  w_accept;
    logic                  r_out_valid;
    logic [CH*W-1:0]       r_data_out;

    assign o_out_valid = r_out_valid;
    assign o_data_out  = r_data_out;

    // Window selections beyond the history depth clamp to the deepest window.
    assign w_win_lat = (i_win_sel > WSW'(LOG2_MAX)) ? WSW'(LOG2_MAX) : i_win_sel;

    // Datapath for the channel currently in CALC.
    assign w_n       = FW'(1) << r_win_cur;
    // Truncation makes N = DMAX read back the slot about to be overwritten.
    assign w_rd_idx  = r_wp - w_n[LOG2_MAX-1:0];
    assign w_xs      = r_frame[r_ch*W +: W];
    assign w_x       = {{LOG2_MAX{w_xs[W-1]}}, w_xs};
    // Taps older than the samples seen since the last flush count as zero.
    assign w_old     = (r_fill < w_n) ? '0 : r_hist[r_ch][w_rd_idx];
    assign w_acc_nxt = r_acc[r_ch] + w_x - w_old;
    assign w_y       = i_bypass ? w_xs : W'(w_acc_nxt >>> r_win_cur);

    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_in_ready = !i_clear;
                if (i_in_valid && !i_clear) w_state_nxt = StCalc;
            end
            StCalc: if (r_ch == CHW'(CH - 1)) w_state_nxt = StDone;
            StDone: w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    assign w_accept = i_in_valid && o_in_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_ch        <= '0;
            r_frame     <= '0;
            r_win_cur   <= '0;
            r_wp        <= '0;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            for (int c = 0; c < CH; c++) begin
                r_acc[c] <= '0;
                r_y[c]   <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_clear) begin
                        r_fill <= '0;
                        for (int c = 0; c < CH; c++) r_acc[c] <= '0;
                    end else if (w_accept) begin
                        r_frame <= i_data_in;
                        r_ch    <= '0;
                        // A new window restarts the average from this sample.
                        if (w_win_lat != r_win_cur) begin
                            r_win_cur <= w_win_lat;
                            r_fill    <= '0;
                            for (int c = 0; c < CH; c++) r_acc[c] <= '0;
                        end
                    end
                end
                StCalc: begin
                    r_acc[r_ch] <= w_acc_nxt;
                    r_y[r_ch]   <= w_y;
                    r_ch        <= r_ch + 1'b1;
                end
                StDone: begin
                    r_out_valid <= 1'b1;
                    for (int c = 0; c < CH; c++) r_data_out[c*W +: W] <= r_y[c];
                    r_wp <= r_wp + 1'b1;
                    if (r_fill != FW'(DMAX)) r_fill <= r_fill + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // History is data only; fill gating keeps unwritten slots from being used.
    always_ff @(posedge i_clk) begin
        if (r_state == StCalc) r_hist[r_ch][r_wp] <= w_x;
    end

endmodule

// File: tb/tb_multich_moving_avg.sv
module tb_multich_moving_avg;

    localparam int W    = 24;
    localparam int CH   = 2;
    localparam int L2   = 4;
    localparam int DMAX = 16;
    localparam int WSW  = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clear;
    logic            bypass;
    logic [WSW-1:0]  win_sel;
    logic            in_valid;
    logic            in_ready;
    logic [CH*W-1:0] data_in;
    logic            out_valid;
    logic [CH*W-1:0] data_out;

    multich_moving_avg #(.W(W), .CH(CH), .LOG2_MAX(L2)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_clear    (clear),
        .i_bypass   (bypass),
        .i_win_sel  (win_sel),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_data_in  (data_in),
        .o_out_valid(out_valid),
        .o_data_out (data_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint dut_ch(input int c);
        logic signed [W-1:0] v;
        v = data_out[c*W +: W];
        return longint'(v);
    endfunction

    // Reference model: remembered samples per channel since the last flush.
    longint hq [CH][$];
    int     m_win;
    longint m_x   [CH];
    longint m_exp [CH];

    task automatic model_flush();
        for (int c = 0; c < CH; c++) hq[c].delete();
    endtask

    task automatic model_accept(input int ws, input bit byp);
        int wl;
        wl = (ws > L2) ? L2 : ws;
        if (wl != m_win) begin
            model_flush();
            m_win = wl;
        end
        for (int c = 0; c < CH; c++) begin
            longint sum;
            int n;
            logic signed [W-1:0] t;
            hq[c].push_back(m_x[c]);
            if (hq[c].size() > DMAX) void'(hq[c].pop_front());
            n = 1 << m_win;
            if (n > hq[c].size()) n = hq[c].size();
            sum = 0;
            for (int k = 0; k < n; k++) sum += hq[c][hq[c].size() - 1 - k];
            t = W'(sum >>> m_win);
            m_exp[c] = byp ? m_x[c] : longint'(t);
        end
    endtask

    // Offer one frame, wait for accept and result, compare with the model.
    task automatic send_frame(input int ws, input bit byp, input longint xl, input longint xr,
                              input string tag);
        logic signed [W-1:0] sl, sr;
        int k, lat;
        sl = W'(xl);
        sr = W'(xr);
        m_x[0]   = longint'(sl);
        m_x[1]   = longint'(sr);
        win_sel  = WSW'(ws);
        bypass   = byp;
        data_in  = {sr, sl};
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check($sformatf("%s ready", tag), longint'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_accept(ws, byp);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check($sformatf("%s latency", tag), lat, CH + 1);
        for (int c = 0; c < CH; c++)
            check($sformatf("%s ch%0d", tag, c), dut_ch(c), m_exp[c]);
    endtask

    // Clear requested together with a frame: the frame must be refused.
    task automatic clear_op(input string tag);
        int pulses;
        clear    = 1'b1;
        in_valid = 1'b1;
        data_in  = {24'd7, 24'd7};
        #1;
        check($sformatf("%s ready low", tag), longint'(in_ready), 0);
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        model_flush();
        pulses = 0;
        for (int i = 0; i < CH + 2; i++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        check($sformatf("%s no frame", tag), pulses, 0);
    endtask

    typedef struct {
        int     ws;
        bit     byp;
        bit     clr;
        int     rep;
        longint xl;
        longint xr;
        longint el;
        longint er;
    } vec_t;

    vec_t tv [13];

    initial begin
        int pulses;
        longint last_l;

        tv[0]  = '{2, 0, 0, 1,  100, -100,  25,  -25};
        tv[1]  = '{2, 0, 0, 1,  100, -100,  50,  -50};
        tv[2]  = '{2, 0, 0, 1,  100, -100,  75,  -75};
        tv[3]  = '{2, 0, 0, 1,  100, -100, 100, -100};
        tv[4]  = '{4, 0, 0, 16,  64,   64,  64,   64};
        tv[5]  = '{1, 0, 0, 1,   32,   32,  16,   16};
        tv[6]  = '{1, 0, 0, 1,   32,   32,  32,   32};
        tv[7]  = '{1, 0, 1, 1,    0,    0,   0,    0};
        tv[8]  = '{1, 0, 0, 1,   32,   32,  16,   16};
        tv[9]  = '{3, 1, 0, 8,   48,   48,  48,   48};
        tv[10] = '{3, 0, 0, 1,   48,   48,  48,   48};
        tv[11] = '{7, 0, 0, 1,  160, -160,  10,  -10};
        tv[12] = '{5, 0, 0, 1,  160, -160,  20,  -20};

        rst_n = 1'b0; clear = 1'b0; bypass = 1'b0; win_sel = '0;
        in_valid = 1'b0; data_in = '0;
        model_flush();
        m_win = 0;

        // Reset values.
        #2;
        check("rst in_ready", longint'(in_ready), 1);
        check("rst out_valid", longint'(out_valid), 0);
        check("rst data_out", longint'(data_out), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (out_valid || data_out != '0) pulses++;
        end
        check("idle after reset quiet", pulses, 0);

        // Ramp to steady state at N=16.
        for (int k = 1; k <= 20; k++) begin
            send_frame(4, 0, 64, 64, $sformatf("ramp%0d", k));
            check($sformatf("ramp%0d exp", k), dut_ch(0), (4 * k > 64) ? 64 : 4 * k);
            @(posedge clk); #1;
            check($sformatf("ramp%0d pulse", k), longint'(out_valid), 0);
            check($sformatf("ramp%0d hold", k), dut_ch(1), m_exp[1]);
        end

        // Directed table: stereo independence, window change, clear, bypass, clamp.
        foreach (tv[i]) begin
            if (tv[i].clr) begin
                clear_op($sformatf("tv%0d clear", i));
            end else begin
                for (int r = 0; r < tv[i].rep; r++)
                    send_frame(tv[i].ws, tv[i].byp, tv[i].xl, tv[i].xr,
                               $sformatf("tv%0d.%0d", i, r));
                check($sformatf("tv%0d L", i), dut_ch(0), tv[i].el);
                check($sformatf("tv%0d R", i), dut_ch(1), tv[i].er);
            end
        end

        // Floor on negative input, with in_valid held high back to back.
        clear_op("pre-floor clear");
        win_sel  = 3'd4;
        bypass   = 1'b0;
        data_in  = {24'hFFFFFF, 24'hFFFFFF};
        m_x[0]   = -1;
        m_x[1]   = -1;
        in_valid = 1'b1;
        pulses   = 0;
        for (int i = 0; i < 40 * (CH + 2); i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                pulses++;
                model_accept(4, 0);
                check($sformatf("floor%0d L", pulses), dut_ch(0), -1);
                check($sformatf("floor%0d R", pulses), dut_ch(1), m_exp[1]);
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < CH + 3; i++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        check("continuous accept count", pulses, 40);
        last_l = dut_ch(0);
        check("floor output held", last_l, -1);

        // Asynchronous reset in the middle of a frame.
        data_in  = {24'd500, 24'd500};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst data_out", longint'(data_out), 0);
        check("midrst out_valid", longint'(out_valid), 0);
        check("midrst in_ready", longint'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        model_flush();
        m_win = 0;
        pulses = 0;
        for (int i = 0; i < CH + 3; i++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        check("midrst frame dropped", pulses, 0);

        // Randomised frames against the model.
        begin
            int ws;
            ws = 2;
            for (int n = 0; n < 150; n++) begin
                logic signed [W-1:0] rl, rr;
                if ($urandom_range(0, 7) == 0) ws = $urandom_range(0, 7);
                if ($urandom_range(0, 14) == 0) clear_op($sformatf("rnd%0d clear", n));
                rl = W'($urandom);
                rr = W'($urandom);
                send_frame(ws, ($urandom_range(0, 5) == 0), longint'(rl), longint'(rr),
                           $sformatf("rnd%0d", n));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
